// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core slice: opcode constants, memory sizing
// and the instruction-memory loader state encoding.
package mips_pkg;

    localparam int IMEM_DEPTH_DEFAULT = 128;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FIN   = 2'd3
    } loader_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/word_packer.sv
// Big-endian 4-byte assembler: each accepted byte shifts in at the bottom, so
// the first byte of a word ends up in [31:24] after four accepts.
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        accept,
    input  logic        clear,
    output logic [31:0] word,
    output logic        full
);

    logic [1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word  <= 32'd0;
            count <= 2'd0;
        end else if (accept) begin
            word  <= {word[23:0], byte_in};
            count <= count + 2'd1;
        end
    end

    // Three bytes held: the next accept completes the word (count wraps to 0).
    assign full = (count == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a program byte-by-byte into instruction memory while holding the CPU.
// Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    load_len,
    input  logic [7:0]    byte_in,
    input  logic          byte_valid,
    output logic          byte_ready,
    output logic          wr_en,
    output logic [31:0]   wr_addr,
    output logic [31:0]   wr_data,
    output logic          busy,
    output logic          cpu_hold,
    output logic          done,
    output logic          err,
    output loader_state_t dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    loader_state_t    state;
    logic [7:0]       len;
    logic [IDX_W-1:0] word_idx;
    logic             err_q;

    logic [31:0]      len_ext;
    logic [31:0]      idx_ext;
    logic             len_ok;
    logic             last_word;
    logic             accept;
    logic             pk_clear;
    logic             pk_full;
    logic [31:0]      pk_word;

    assign len_ext   = {24'd0, load_len};
    assign len_ok    = (len_ext != 32'd0) && (len_ext <= 32'(DEPTH));
    assign idx_ext   = 32'(word_idx);
    assign last_word = (idx_ext == ({24'd0, len} - 32'd1));

    assign accept   = byte_valid && byte_ready;
    // Byte count restarts on every new session and after every written word.
    assign pk_clear = ((state == ST_IDLE) && start && len_ok) || (state == ST_WRITE);

    word_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .byte_in (byte_in),
        .accept  (accept),
        .clear   (pk_clear),
        .word    (pk_word),
        .full    (pk_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            len      <= 8'd0;
            word_idx <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            len      <= load_len;
                            word_idx <= '0;
                            state    <= ST_RECV;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (accept && pk_full) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (last_word) begin
                        state <= ST_FIN;
                    end else begin
                        word_idx <= word_idx + 1'b1;
                        state    <= ST_RECV;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state; gating with reset keeps them quiet
    // during the reset cycle itself, before the state register has cleared.
    assign byte_ready = (state == ST_RECV) && !reset;
    assign wr_en      = (state == ST_WRITE) && !reset;
    assign wr_addr    = wr_en ? {idx_ext[29:0], 2'b00} : 32'd0;
    assign wr_data    = wr_en ? pk_word : 32'd0;
    assign busy       = (state != ST_IDLE) && !reset;
    assign cpu_hold   = busy;
    assign done       = (state == ST_FIN) && !reset;
    assign err        = err_q && !reset;
    assign dbg_state  = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued by the driver and
// consumed by an independent monitor that watches wr_en.
module tb_imem_loader;
    import mips_pkg::*;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    load_len = 8'd0;
    logic [7:0]    byte_in = 8'd0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          wr_en;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic          err;
    loader_state_t dbg_state;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_len   (load_len),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    logic [63:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit prev_wr = 1'b0;
    bit busy_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: pops one expected {addr,data} per write strobe.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_seen = 1'b1;
        if (err === 1'b1) err_cnt++;
        if (wr_en === 1'b1) begin
            wr_cnt++;
            check("wr_byte_ready_low", 64'(byte_ready), 64'd0);
            check("wr_cpu_hold", 64'(cpu_hold), 64'd1);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL wr_unexpected: got addr %h data %h expected no write", wr_addr, wr_data);
            end else begin
                check("wr_addr_data", {wr_addr, wr_data}, exp_q.pop_front());
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            check("done_after_wr", 64'(prev_wr), 64'd1);
        end
        prev_wr = (wr_en === 1'b1);
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_flags", 64'({byte_ready, wr_en, busy, cpu_hold, done, err}), 64'd0);
        check("reset_bus", {wr_addr, wr_data}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_state", 64'(dbg_state), 64'(ST_IDLE));
    endtask

    task automatic start_session(input logic [7:0] len);
        start = 1'b1;
        load_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_in = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("byte_ready_timeout", 64'(byte_ready), 64'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
        @(negedge clk);
    endtask

    function automatic logic [63:0] wr(input logic [31:0] a, input logic [31:0] d);
        return {a, d};
    endfunction

    initial begin
        int w0;
        int d0;
        int e0;

        // Test 1: single word
        do_reset();
        w0 = wr_cnt; d0 = done_cnt;
        exp_q.push_back(wr(32'h0, 32'h20020005));
        start_session(8'd1);
        send_word(32'h20020005);
        wait_done();
        check("t1_writes", 64'(wr_cnt - w0), 64'd1);
        check("t1_dones", 64'(done_cnt - d0), 64'd1);
        check("t1_busy_idle", 64'({busy, cpu_hold}), 64'd0);

        // Test 2: three words back-to-back
        w0 = wr_cnt; d0 = done_cnt;
        exp_q.push_back(wr(32'h0, 32'h20080001));
        exp_q.push_back(wr(32'h4, 32'h8c090004));
        exp_q.push_back(wr(32'h8, 32'had2a0008));
        start_session(8'd3);
        send_word(32'h20080001);
        send_word(32'h8c090004);
        send_word(32'had2a0008);
        wait_done();
        check("t2_writes", 64'(wr_cnt - w0), 64'd3);
        check("t2_dones", 64'(done_cnt - d0), 64'd1);

        // Test 3: rejected lengths
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        busy_seen = 1'b0;
        start_session(8'd0);
        start_session(8'd129);
        repeat (4) @(negedge clk);
        check("t3_errs", 64'(err_cnt - e0), 64'd2);
        check("t3_writes", 64'(wr_cnt - w0), 64'd0);
        check("t3_dones", 64'(done_cnt - d0), 64'd0);
        check("t3_busy_seen", 64'(busy_seen), 64'd0);

        // Test 4: byte_valid gap after the 2nd byte
        w0 = wr_cnt;
        exp_q.push_back(wr(32'h0, 32'h3c011001));
        exp_q.push_back(wr(32'h4, 32'h34280000));
        start_session(8'd2);
        send_byte(8'h3c);
        send_byte(8'h01);
        repeat (5) @(negedge clk);
        check("t4_stall_state", 64'(dbg_state), 64'(ST_RECV));
        send_byte(8'h10);
        send_byte(8'h01);
        send_word(32'h34280000);
        wait_done();
        check("t4_writes", 64'(wr_cnt - w0), 64'd2);

        // Test 5: reset after the 6th byte aborts the session
        w0 = wr_cnt; d0 = done_cnt;
        exp_q.push_back(wr(32'h0, 32'h11223344));
        start_session(8'd2);
        send_word(32'h11223344);
        send_byte(8'h55);
        send_byte(8'h66);
        do_reset();
        repeat (3) @(negedge clk);
        check("t5_writes", 64'(wr_cnt - w0), 64'd1);
        check("t5_dones", 64'(done_cnt - d0), 64'd0);
        check("t5_idle_bus", {wr_addr, wr_data}, 64'd0);
        exp_q.push_back(wr(32'h0, 32'hdeadbeef));
        start_session(8'd1);
        send_word(32'hdeadbeef);
        wait_done();
        check("t5_restart_writes", 64'(wr_cnt - w0), 64'd2);

        // Test 6: start while busy is ignored
        w0 = wr_cnt; d0 = done_cnt;
        exp_q.push_back(wr(32'h0, 32'h01020304));
        exp_q.push_back(wr(32'h4, 32'h05060708));
        start_session(8'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        start_session(8'd5);
        send_byte(8'h03);
        send_byte(8'h04);
        send_word(32'h05060708);
        wait_done();
        repeat (3) @(negedge clk);
        check("t6_writes", 64'(wr_cnt - w0), 64'd2);
        check("t6_dones", 64'(done_cnt - d0), 64'd1);
        check("t6_idle", 64'(busy), 64'd0);

        // Test 7: full-depth session, last word lands at 0x1fc
        w0 = wr_cnt;
        for (int i = 0; i < 128; i++) begin
            exp_q.push_back(wr(32'(i) << 2, {8'(i), 8'hc3, 8'(255 - i), 8'h5a}));
        end
        start_session(8'd128);
        for (int i = 0; i < 128; i++) begin
            send_word({8'(i), 8'hc3, 8'(255 - i), 8'h5a});
        end
        wait_done();
        check("t7_writes", 64'(wr_cnt - w0), 64'd128);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 128, instruction memory depth in 32-bit words.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin a load session; sampled in IDLE only.
REQ-005 load_len  input  8  number of words to load, latched on accepted start.
REQ-006 byte_in  input  8  program byte stream.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 wr_en  output  1  instruction memory write strobe, one cycle per word.
REQ-010 wr_addr  output  32  byte address of the write, word-aligned, so bits [31:2] are the word index.
REQ-011 wr_data  output  32  assembled instruction word.
REQ-012 busy  output  1  session in progress.
REQ-013 cpu_hold  output  1  equals busy; keeps the processor PC in reset while memory is written.
REQ-014 done  output  1  one-cycle pulse when the session completes.
REQ-015 err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-016 The FSM SHALL have the states IDLE, RECV, WRITE and FIN.
REQ-017 In IDLE, start=1 with 1<=load_len<=DEPTH SHALL latch load_len, clear the word index and byte count, and go to RECV next cycle.
REQ-018 In IDLE, start=1 with load_len=0 or load_len>DEPTH SHALL pulse err for one cycle and stay in IDLE.
REQ-019 byte_ready SHALL be 1 only in RECV; a byte is accepted only when byte_valid&&byte_ready.
REQ-020 Bytes SHALL be assembled big-endian: the 1st accepted byte goes to [31:24], the 2nd to [23:16], the 3rd to [15:8] and the 4th to [7:0].
REQ-021 Acceptance of the 4th byte SHALL move the FSM to WRITE; wr_en SHALL be 1 for exactly that one WRITE cycle.
REQ-022 In WRITE, wr_addr SHALL equal {word_idx,2'b00} and wr_data SHALL be the assembled word; wr_en, wr_addr and wr_data SHALL be driven combinationally from state.
REQ-023 After WRITE, if word_idx==len-1 the FSM SHALL go to FIN; otherwise word_idx SHALL increment, the byte count SHALL clear, and the FSM SHALL return to RECV.
REQ-024 The latency from acceptance of a word's last byte to its wr_en SHALL be exactly 1 cycle.
REQ-025 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-026 busy SHALL be 1 in RECV, WRITE and FIN, and 0 in IDLE.
REQ-027 start SHALL be ignored while busy.
REQ-028 A byte_valid gap SHALL stall assembly indefinitely with no timeout; partial bytes are retained.
REQ-029 When inactive, wr_addr and wr_data SHALL be 0.
REQ-030 The byte counter SHALL be 2 bits wide and the word index SHALL be clog2(DEPTH) bits wide; word_idx SHALL never exceed DEPTH-1.

Reset
REQ-031 reset SHALL force IDLE and clear the assembly register, byte count, word index and latched length.
REQ-032 During and after reset, byte_ready, wr_en, busy, cpu_hold, done and err SHALL be 0, and wr_addr and wr_data SHALL be 0.
REQ-033 reset mid-session SHALL abort the session without a wr_en or done pulse; words already written remain in memory.

Structure
REQ-034 State encodings and the DEPTH default SHALL live in the shared package mips_pkg, alongside the opcode constants.
REQ-035 The 4-byte big-endian assembler SHALL be a sub-module named word_packer (inputs: byte, accept, clear; outputs: word, full).

Verification
REQ-036 Test 1: reset, then start with load_len=1 and bytes 20 02 00 05 -> one wr_en with wr_addr=0x0 and wr_data=0x20020005, done 1 cycle after wr_en, busy back to 0.
REQ-037 Test 2: load_len=3 with 12 bytes streamed back-to-back -> wr_en at addresses 0x0, 0x4 and 0x8, byte_ready=0 in each WRITE cycle, exactly 3 writes.
REQ-038 Test 3: start with load_len=0, then start with load_len=129 -> err pulses twice, and busy, wr_en and done stay 0.
REQ-039 Test 4: load_len=2 with byte_valid deasserted for 5 cycles after the 2nd byte -> wr_data is still correct and no spurious wr_en occurs.
REQ-040 Test 5: reset asserted after the 6th byte of a load_len=2 session -> no second wr_en, no done, all outputs 0; a new session then writes from 0x0.
REQ-041 Test 6: start pulsed while busy with a different load_len -> ignored; the write count matches the original load_len.
